// File: rtl/fifo_rd_stream_stage_pkg.sv
// Shared constants and helpers for the asynchronous FIFO read-side stream stage.
package fifo_rd_stream_stage_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int RD_LATENCY_MIN  = 1;
    localparam int RD_LATENCY_MAX  = 3;

    // Width of a counter that must hold every value from 0 up to depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Memory read latencies the stage is built to track.
    function automatic bit rd_latency_legal(input int lat);
        return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/d_ff_async.sv
// Plain D flip-flop with asynchronous active-high reset to zero.
module d_ff_async #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register d every clock, clear immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fifo_rd_stream_stage_sync_output_buffer.sv
// Single-clock register queue holding words that have come back from the
// FIFO memory but have not yet been taken by the consumer.
module sync_output_buffer
    import fifo_rd_stream_stage_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_push_data,
    input  logic                          i_pop,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_head_data,
    output logic [level_width(DEPTH)-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;

    // Storage: cleared on reset so the head word is never X, written at the tail on push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally; occupancy comes from the level counter, not a pointer compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // A push into a full buffer means the upstream credit accounting is broken.
    always @(posedge clk) begin
        if (!rst) begin
            a_no_overflow: assert (!(i_push && (r_level == LEVEL_FULL)));
        end
    end

    assign o_valid     = (r_level != '0);
    assign o_head_data = r_mem[r_rd_ptr];
    assign o_level     = r_level;

endmodule

// File: rtl/fifo_rd_stream_stage.sv
// Read-side output stage of the asynchronous FIFO: turns empty/rd_en/latent
// read data into a first-word-fall-through valid/ready stream, issuing reads
// only when the buffer is guaranteed to have room for every word in flight.
module fifo_rd_stream_stage
    import fifo_rd_stream_stage_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]             fifo_rd_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [level_width(BUF_DEPTH)-1:0] out_level
);

    localparam int LW = level_width(BUF_DEPTH);
    localparam logic [LW:0] CREDIT_LIMIT = (LW + 1)'(BUF_DEPTH);

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("fifo_rd_stream_stage: RD_LATENCY must be 1..3");
    end
    if ((BUF_DEPTH < RD_LATENCY + 1) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_rd_stream_stage: BUF_DEPTH must be a power of two >= RD_LATENCY+1");
    end

    logic [RD_LATENCY-1:0] w_trk;
    logic [LW-1:0]         w_inflight;
    logic [LW:0]           w_credit_sum;
    logic                  w_pop;
    logic                  w_capture;

    // Stream handshake: out_data is a word transferred on every cycle where
    // out_valid and out_ready are both high; once out_valid rises it and
    // out_data hold until that transfer happens.
    assign w_pop     = out_valid & out_ready;
    assign w_capture = w_trk[RD_LATENCY-1];

    // In-flight tracker: one flop per cycle of memory latency, bit0 sees the read request.
    for (genvar g = 0; g < RD_LATENCY; g++) begin : g_trk
        logic w_d;
        if (g == 0) begin : g_head
            assign w_d = fifo_rd_en;
        end else begin : g_tail
            assign w_d = w_trk[g-1];
        end
        d_ff_async #(.WIDTH(1)) u_ff (
            .clk (clk),
            .rst (rst),
            .d   (w_d),
            .q   (w_trk[g])
        );
    end

    // Count reads issued whose data has not yet been captured.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + LW'(w_trk[i]);
        end
    end

    // Credit: buffered + in flight, minus the slot freed by this cycle's pop.
    assign w_credit_sum = {1'b0, out_level} + {1'b0, w_inflight} - (LW + 1)'(w_pop);
    assign fifo_rd_en   = !rst && !fifo_empty && (w_credit_sum < CREDIT_LIMIT);

    sync_output_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_capture),
        .i_push_data (fifo_rd_data),
        .i_pop       (w_pop),
        .o_valid     (out_valid),
        .o_head_data (out_data),
        .o_level     (out_level)
    );

endmodule

// File: tb/tb_fifo_rd_stream_stage.sv
// Bench for fifo_rd_stream_stage: two instances (read latency 1 and 3) each fed
// by a small behavioural FIFO with a registered empty flag and a read-data pipe.
module tb_fifo_rd_stream_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // clock
    always #5 clk = ~clk;

    // stream a: RD_LATENCY = 1
    logic       a_empty;
    logic       a_rd_en;
    logic [7:0] a_rd_data;
    logic       a_valid;
    logic       a_ready = 1'b0;
    logic [7:0] a_data;
    logic [2:0] a_level;
    logic [7:0] a_src_mem [128];
    int         a_src_wr = 0;
    int         a_src_rd = 0;
    logic [7:0] a_pipe [1];

    // stream b: RD_LATENCY = 3
    logic       b_empty;
    logic       b_rd_en;
    logic [7:0] b_rd_data;
    logic       b_valid;
    logic       b_ready = 1'b0;
    logic [7:0] b_data;
    logic [2:0] b_level;
    logic [7:0] b_src_mem [128];
    int         b_src_wr = 0;
    int         b_src_rd = 0;
    logic [7:0] b_pipe [3];

    logic [7:0] a_exp_q [$];
    logic [7:0] b_exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       ready;
        logic       en;
        logic       valid;
        logic [2:0] level;
        logic [7:0] data;
    } vec_t;
    vec_t tbl [27];

    fifo_rd_stream_stage #(.DATA_WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(4)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (a_empty),
        .fifo_rd_en   (a_rd_en),
        .fifo_rd_data (a_rd_data),
        .out_valid    (a_valid),
        .out_ready    (a_ready),
        .out_data     (a_data),
        .out_level    (a_level)
    );

    fifo_rd_stream_stage #(.DATA_WIDTH(8), .RD_LATENCY(3), .BUF_DEPTH(4)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (b_empty),
        .fifo_rd_en   (b_rd_en),
        .fifo_rd_data (b_rd_data),
        .out_valid    (b_valid),
        .out_ready    (b_ready),
        .out_data     (b_data),
        .out_level    (b_level)
    );

    // FIFO models: pop on rd_en, registered empty, data appears RD_LATENCY cycles later
    assign a_rd_data = a_pipe[0];
    assign b_rd_data = b_pipe[2];

    always @(posedge clk) begin
        a_pipe[0] <= a_rd_en ? a_src_mem[a_src_rd[6:0]] : 8'hEE;
        a_src_rd  <= a_src_rd + (a_rd_en ? 1 : 0);
        a_empty   <= ((a_src_rd + (a_rd_en ? 1 : 0)) == a_src_wr);
    end

    always @(posedge clk) begin
        b_pipe[0] <= b_rd_en ? b_src_mem[b_src_rd[6:0]] : 8'hEE;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
        b_src_rd  <= b_src_rd + (b_rd_en ? 1 : 0);
        b_empty   <= ((b_src_rd + (b_rd_en ? 1 : 0)) == b_src_wr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every accepted word must be the next one loaded into that FIFO
    always @(negedge clk) begin
        if (!rst && (a_valid === 1'b1) && a_ready) begin
            if (a_exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_extra_word: got 0x%0h, expected no word at %0t", a_data, $time);
            end else begin
                chk("a_stream_data", 32'(a_data), 32'(a_exp_q.pop_front()));
            end
        end
        if (!rst && (b_valid === 1'b1) && b_ready) begin
            if (b_exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_extra_word: got 0x%0h, expected no word at %0t", b_data, $time);
            end else begin
                chk("b_stream_data", 32'(b_data), 32'(b_exp_q.pop_front()));
            end
        end
    end

    task automatic load_a(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            a_src_mem[a_src_wr[6:0]] = first + 8'(i);
            a_exp_q.push_back(first + 8'(i));
            a_src_wr++;
        end
    endtask

    task automatic load_b(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            b_src_mem[b_src_wr[6:0]] = first + 8'(i);
            b_exp_q.push_back(first + 8'(i));
            b_src_wr++;
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic v, input int l, input int d);
        vec_t t;
        t.ready = r;
        t.en    = e;
        t.valid = v;
        t.level = 3'(l);
        t.data  = 8'(d);
        return t;
    endfunction

    // one row per cycle on stream a: drive ready, then check mid-cycle
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(posedge clk);
            #1;
            a_ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("row%0d_rd_en", i), 32'(a_rd_en), 32'(tbl[i].en));
            chk($sformatf("row%0d_valid", i), 32'(a_valid), 32'(tbl[i].valid));
            chk($sformatf("row%0d_level", i), 32'(a_level), 32'(tbl[i].level));
            if (tbl[i].valid) begin
                chk($sformatf("row%0d_data", i), 32'(a_data), 32'(tbl[i].data));
            end
        end
    endtask

    initial begin
        int rd_cnt;
        int guard;

        // rows 0..10: 0x10..0x17 with consumer always ready
        tbl[0] = mk(1, 1, 0, 0, 0);
        tbl[1] = mk(1, 1, 0, 0, 0);
        for (int i = 2; i < 8; i++) tbl[i] = mk(1, 1, 1, 1, 8'h10 + i - 2);
        tbl[8]  = mk(1, 0, 1, 1, 8'h16);
        tbl[9]  = mk(1, 0, 1, 1, 8'h17);
        tbl[10] = mk(1, 0, 0, 0, 0);
        // rows 11..26: same stream, consumer stalled until the buffer fills
        tbl[11] = mk(0, 1, 0, 0, 0);
        tbl[12] = mk(0, 1, 0, 0, 0);
        tbl[13] = mk(0, 1, 1, 1, 8'h10);
        tbl[14] = mk(0, 1, 1, 2, 8'h10);
        tbl[15] = mk(0, 0, 1, 3, 8'h10);
        tbl[16] = mk(0, 0, 1, 4, 8'h10);
        tbl[17] = mk(0, 0, 1, 4, 8'h10);
        tbl[18] = mk(1, 1, 1, 4, 8'h10);
        tbl[19] = mk(1, 1, 1, 3, 8'h11);
        tbl[20] = mk(1, 1, 1, 3, 8'h12);
        tbl[21] = mk(1, 1, 1, 3, 8'h13);
        tbl[22] = mk(1, 0, 1, 3, 8'h14);
        tbl[23] = mk(1, 0, 1, 3, 8'h15);
        tbl[24] = mk(1, 0, 1, 2, 8'h16);
        tbl[25] = mk(1, 0, 1, 1, 8'h17);
        tbl[26] = mk(1, 0, 0, 0, 0);

        // reset, then idle with both FIFOs empty
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_rd_en", 32'(a_rd_en), 32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_level", 32'(a_level), 32'd0);
        chk("rst_a_data",  32'(a_data),  32'd0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_a_rd_en", 32'(a_rd_en), 32'd0);
            chk("idle_a_valid", 32'(a_valid), 32'd0);
            chk("idle_a_level", 32'(a_level), 32'd0);
            chk("idle_a_data",  32'(a_data),  32'd0);
            chk("idle_b_rd_en", 32'(b_rd_en), 32'd0);
            chk("idle_b_valid", 32'(b_valid), 32'd0);
            chk("idle_b_level", 32'(b_level), 32'd0);
            chk("idle_b_data",  32'(b_data),  32'd0);
        end

        // full-rate stream
        @(posedge clk);
        #1;
        load_a(8'h10, 8);
        run_rows(0, 11);

        // stalled consumer, then release
        @(posedge clk);
        #1;
        a_ready = 1'b0;
        load_a(8'h10, 8);
        run_rows(11, 27);

        // ready toggling every cycle over 16 words
        @(posedge clk);
        #1;
        load_a(8'h20, 16);
        guard = 0;
        while ((a_exp_q.size() != 0) && (guard < 200)) begin
            a_ready = (guard % 2 == 0);
            @(negedge clk);
            chk("toggle_level_max", 32'(a_level <= 3'd4), 32'd1);
            @(posedge clk);
            #1;
            guard++;
        end
        chk("toggle_drained", 32'(a_exp_q.size()), 32'd0);
        a_ready = 1'b0;

        // latency 3: FIFO runs dry after two reads
        @(posedge clk);
        #1;
        b_ready = 1'b1;
        load_b(8'hA0, 2);
        rd_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (b_rd_en) rd_cnt++;
        end
        chk("b_dry_reads",   32'(rd_cnt),          32'd2);
        chk("b_dry_level",   32'(b_level),         32'd0);
        chk("b_dry_valid",   32'(b_valid),         32'd0);
        chk("b_dry_drained", 32'(b_exp_q.size()),  32'd0);

        // latency 3: reset with two reads in flight and two words buffered
        @(posedge clk);
        #1;
        b_ready = 1'b0;
        load_b(8'hB0, 8);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("b_pre_reset_level", 32'(b_level), 32'd2);
        rst = 1'b1;
        #1;
        chk("b_async_rst_valid", 32'(b_valid), 32'd0);
        chk("b_async_rst_level", 32'(b_level), 32'd0);
        chk("b_async_rst_rd_en", 32'(b_rd_en), 32'd0);
        chk("b_async_rst_data",  32'(b_data),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // words already popped from the FIFO are gone; the stream resumes at the next one
        while (b_exp_q.size() > (b_src_wr - b_src_rd)) begin
            void'(b_exp_q.pop_front());
        end
        repeat (4) begin
            @(negedge clk);
            chk("b_no_stale_capture", 32'(b_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        b_ready = 1'b1;
        guard = 0;
        while ((b_exp_q.size() != 0) && (guard < 50)) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("b_restart_drained", 32'(b_exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("b_final_level", 32'(b_level), 32'd0);
        chk("a_final_drained", 32'(a_exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
